// File: rtl/rc4_pkg.sv
// Shared constants, state type and plaintext legality check for the RC4 key-search path.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEF = 32;
    localparam int unsigned KEY_W       = 24;
    localparam logic [21:0] KEY_MAX_DEF = 22'h3FFFFF;

    localparam logic [7:0] ASCII_LO = 8'h61;
    localparam logic [7:0] ASCII_HI = 8'h7A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StScan,
        StNext,
        StDoneOk,
        StDoneFail
    } ks_state_t;

    function automatic logic is_legal(input logic [7:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
    endfunction

endpackage

// File: rtl/msg_scanner.sv
// Walks the decrypted message RAM once per scan_go, checking each byte the cycle after its
// address is issued; reports scan_done/scan_ok on the first illegal byte or after the last one.
module msg_scanner
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_go,
    input  logic [7:0] aOut,
    output logic [7:0] aAddr,
    output logic       scan_done,
    output logic       scan_ok
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    logic [7:0] idx_q, idx_d;
    logic       issue_q, issue_d;
    logic       chk_q, chk_d;
    logic       last_q, last_d;

    always_comb begin
        idx_d     = idx_q;
        issue_d   = issue_q;
        chk_d     = 1'b0;
        last_d    = last_q;
        scan_done = 1'b0;
        scan_ok   = 1'b0;

        if (issue_q) begin
            chk_d  = 1'b1;
            last_d = (idx_q == LAST_IDX);
            if (idx_q == LAST_IDX) begin
                issue_d = 1'b0;
            end else begin
                idx_d = idx_q + 8'd1;
            end
        end

        // aOut here is the byte for the address issued last cycle
        if (chk_q) begin
            if (!is_legal(aOut)) begin
                scan_done = 1'b1;
                issue_d   = 1'b0;
                chk_d     = 1'b0;
            end else if (last_q) begin
                scan_done = 1'b1;
                scan_ok   = 1'b1;
            end
        end

        if (scan_go) begin
            idx_d   = '0;
            issue_d = 1'b1;
            chk_d   = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            issue_q <= 1'b0;
            chk_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            issue_q <= issue_d;
            chk_q   <= chk_d;
            last_q  <= last_d;
        end
    end

    assign aAddr = idx_q;

endmodule

// File: rtl/key_search.sv
// Brute-force RC4 key-search controller: launches arcfour per candidate, scans the result.
// KEY_SEARCH_PROGRESS_EN makes key_disp follow the live candidate instead of the final result.
module key_search
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEF,
    parameter logic [21:0] KEY_MAX = KEY_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_sig,
    output logic            arc_start,
    input  logic            arc_finished,
    output logic [2:0][7:0] key,
    output logic [2:0][7:0] key_disp,
    output logic            a_own,
    output logic [7:0]      aAddr,
    input  logic [7:0]      aOut,
    output logic            busy,
    output logic            found,
    output logic            exhausted
);

    ks_state_t        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             arc_start_q, arc_start_d;
    logic             fin_q;
    logic             busy_q, busy_d;
    logic             found_q, found_d;
    logic             exh_q, exh_d;
    logic             fin_rise;
    logic             scan_go;
    logic             scan_done;
    logic             scan_ok;

    assign fin_rise = arc_finished & ~fin_q;
    assign scan_go  = (state_q == StWait) && fin_rise;

    msg_scanner #(
        .MSG_LEN (MSG_LEN)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .scan_go   (scan_go),
        .aOut      (aOut),
        .aAddr     (aAddr),
        .scan_done (scan_done),
        .scan_ok   (scan_ok)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        arc_start_d = 1'b0;
        busy_d      = busy_q;
        found_d     = found_q;
        exh_d       = exh_q;

        unique case (state_q)
            StIdle: begin
                if (start_sig) begin
                    key_d   = '0;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                arc_start_d = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                if (fin_rise) state_d = StScan;
            end
            StScan: begin
                if (scan_done) begin
                    if (scan_ok) begin
                        found_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StDoneOk;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (key_q[21:0] == KEY_MAX) begin
                    exh_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDoneFail;
                end else begin
                    key_d   = key_q + 24'd1;
                    state_d = StLaunch;
                end
            end
            StDoneOk, StDoneFail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            key_q       <= '0;
            arc_start_q <= 1'b0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
            found_q     <= 1'b0;
            exh_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            arc_start_q <= arc_start_d;
            fin_q       <= arc_finished;
            busy_q      <= busy_d;
            found_q     <= found_d;
            exh_q       <= exh_d;
        end
    end

    assign arc_start = arc_start_q;
    assign a_own     = (state_q == StScan);
    assign key       = key_q;
    assign busy      = busy_q;
    assign found     = found_q;
    assign exhausted = exh_q;

`ifdef KEY_SEARCH_PROGRESS_EN
    assign key_disp = key_q;
`else
    logic [KEY_W-1:0] disp_q;

    // Done states are only ever entered from SCAN/NEXT, so state_d marks the deciding cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q <= '0;
        end else if (state_d == StDoneOk || state_d == StDoneFail) begin
            disp_q <= key_q;
        end
    end

    assign key_disp = disp_q;
`endif

endmodule

// File: tb/tb_key_search.sv
// Self-checking bench for key_search: fake arcfour and message RAM around two DUT instances
// (full key space and a 4-key space), checked against a reference model of the search outcome.
module tb_key_search;

    localparam int unsigned MSG_LEN   = 32;
    localparam int unsigned BIG_MAX   = 32'h3FFFFF;
    localparam int unsigned SMALL_MAX = 3;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       start_sig    = 1'b0;
    logic       arc_finished = 1'b0;
    logic [7:0] aOut         = 8'h00;
    logic       sel          = 1'b0;

    logic            arc_start0, a_own0, busy0, found0, exh0;
    logic            arc_start1, a_own1, busy1, found1, exh1;
    logic [7:0]      aAddr0, aAddr1;
    logic [2:0][7:0] key0, key1, disp0, disp1;

    logic        arc_start_s, a_own_s, busy_s, found_s, exh_s;
    logic [7:0]  aAddr_s;
    logic [23:0] key_s, disp_s;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    key_search #(
        .MSG_LEN (MSG_LEN)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_sig    (start_sig & ~sel),
        .arc_start    (arc_start0),
        .arc_finished (arc_finished),
        .key          (key0),
        .key_disp     (disp0),
        .a_own        (a_own0),
        .aAddr        (aAddr0),
        .aOut         (aOut),
        .busy         (busy0),
        .found        (found0),
        .exhausted    (exh0)
    );

    key_search #(
        .MSG_LEN (MSG_LEN),
        .KEY_MAX (22'h000003)
    ) u_dut_small (
        .clk          (clk),
        .reset        (reset),
        .start_sig    (start_sig & sel),
        .arc_start    (arc_start1),
        .arc_finished (arc_finished),
        .key          (key1),
        .key_disp     (disp1),
        .a_own        (a_own1),
        .aAddr        (aAddr1),
        .aOut         (aOut),
        .busy         (busy1),
        .found        (found1),
        .exhausted    (exh1)
    );

    assign arc_start_s = sel ? arc_start1 : arc_start0;
    assign a_own_s     = sel ? a_own1 : a_own0;
    assign busy_s      = sel ? busy1 : busy0;
    assign found_s     = sel ? found1 : found0;
    assign exh_s       = sel ? exh1 : exh0;
    assign aAddr_s     = sel ? aAddr1 : aAddr0;
    assign key_s       = sel ? key1 : key0;
    assign disp_s      = sel ? disp1 : disp0;

    // Message RAM: keys below win_key see bad_byte at bad_pos, every other byte is msg[]
    int unsigned win_key = 0;
    int unsigned bad_pos[16];
    logic [7:0]  bad_byte[16];
    logic [7:0]  msg[MSG_LEN];

    function automatic logic legal(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [23:0] k, input logic [7:0] a);
        if (k < win_key && a == bad_pos[k[3:0]]) return bad_byte[k[3:0]];
        return msg[a[4:0]];
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (legal(b));
        return b;
    endfunction

    function automatic logic [7:0] rand_good();
        int unsigned r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    always @(posedge clk) aOut <= ram_rd(key_s, aAddr_s);

    // Fake arcfour: drops finished after each start, raises it arc_lat cycles later
    int unsigned arc_lat = 10;
    logic        fake_en = 1'b1;

    always begin
        @(negedge clk);
        if (fake_en && arc_start_s) begin
            @(posedge clk);
            #1 arc_finished = 1'b0;
            repeat (arc_lat - 1) @(posedge clk);
            #1 arc_finished = 1'b1;
        end
    end

    // Observation log, sampled mid-cycle
    int unsigned cyc = 0, launches = 0, overlaps = 0, own_len = 0, rise_cyc = 0;
    logic        fin_prev = 1'b0, own_prev = 1'b0;
    int unsigned scan_lens[$];
    int unsigned entry_gaps[$];
    logic [7:0]  addr_log[$];

    always @(negedge clk) begin
        cyc++;
        if (arc_start_s) launches++;
        if (arc_start_s && a_own_s) overlaps++;
        if (arc_finished && !fin_prev) rise_cyc = cyc;
        if (a_own_s) begin
            if (!own_prev) entry_gaps.push_back(cyc - rise_cyc);
            own_len++;
            addr_log.push_back(aAddr_s);
        end else if (own_prev) begin
            scan_lens.push_back(own_len);
            own_len = 0;
        end
        fin_prev = arc_finished;
        own_prev = a_own_s;
    end

    int unsigned disp_hold = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        launches = 0;
        scan_lens.delete();
        entry_gaps.delete();
        addr_log.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start_sig = 1'b1;
        @(posedge clk);
        #1 start_sig = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        while (!(found_s || exh_s) && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(found_s | exh_s), 1);
    endtask

    task automatic wait_own(input int unsigned budget);
        int unsigned n = 0;
        while (!a_own_s && n < budget) begin
            tick();
            n++;
        end
        check("own_timeout", 32'(a_own_s), 1);
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_s), 0);
        check({tag, "_found"}, 32'(found_s), 0);
        check({tag, "_exh"}, 32'(exh_s), 0);
        check({tag, "_a_own"}, 32'(a_own_s), 0);
        check({tag, "_arc_start"}, 32'(arc_start_s), 0);
    endtask

    // Expected outcome from the search rules: first clean key wins, else stop at kmax
    task automatic run_and_check(input int unsigned kmax, input bit mid_start);
        bit          exp_found;
        int unsigned tried;
        int unsigned exp_key;
        int unsigned exp_len;
        exp_found = (win_key <= kmax);
        tried     = exp_found ? win_key + 1 : kmax + 1;
        exp_key   = exp_found ? win_key : kmax;

        clear_log();
        pulse_start();
        tick();
        check("arc_start_n1", 32'(arc_start_s), 0);
        check("busy_n1", 32'(busy_s), 1);
        check("found_clr", 32'(found_s), 0);
        check("key_restart", 32'(key_s), 0);
`ifdef KEY_SEARCH_PROGRESS_EN
        check("disp_mid", 32'(disp_s), 0);
`else
        check("disp_mid", 32'(disp_s), sel ? 0 : disp_hold);
`endif
        tick();
        check("arc_start_n2", 32'(arc_start_s), 1);
        if (mid_start) begin
            wait_own(40);
            pulse_start();
        end
        wait_done(tried * (MSG_LEN + 20) + 50);
        check("found", 32'(found_s), 32'(exp_found));
        check("exhausted", 32'(exh_s), 32'(!exp_found));
        check("busy_done", 32'(busy_s), 0);
        check("key", 32'(key_s), exp_key);
        check("key_disp", 32'(disp_s), exp_key);
        check("launches", launches, tried);
        check("scan_count", scan_lens.size(), tried);
        for (int i = 0; i < scan_lens.size() && i < int'(tried); i++) begin
            exp_len = (i < int'(win_key)) ? bad_pos[i] + 2 : MSG_LEN + 1;
            check("scan_len", scan_lens[i], exp_len);
        end
        for (int i = 0; i < entry_gaps.size(); i++) check("rise_to_addr0", entry_gaps[i], 1);
        if (!sel) disp_hold = exp_key;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) tick();
        check_rst_outputs("rst");
        check("rst_key", 32'(key_s), 0);
        check("rst_disp", 32'(disp_s), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) tick();

        // All 'a': key 0 wins, one full sweep of the message
        for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'h61;
        win_key = 0;
        run_and_check(BIG_MAX, 1'b0);
        check("sweep_len", addr_log.size(), MSG_LEN + 1);
        for (int i = 0; i < addr_log.size() && i < MSG_LEN; i++)
            check("sweep_addr", 32'(addr_log[i]), i);
        repeat (3) tick();

        // Byte 3 = 'A' for keys 0..4, with a stray start pulse during the first scan
        for (int i = 0; i < MSG_LEN; i++) msg[i] = rand_good();
        for (int k = 0; k < 16; k++) begin
            bad_pos[k]  = 3;
            bad_byte[k] = 8'h41;
        end
        win_key = 5;
        run_and_check(BIG_MAX, 1'b1);
        repeat (3) tick();

        // Restart after a find: flags clear, key restarts at 0
        win_key = 0;
        run_and_check(BIG_MAX, 1'b0);
        repeat (3) tick();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < MSG_LEN; i++) msg[i] = rand_good();
            for (int k = 0; k < 16; k++) begin
                bad_pos[k]  = $urandom_range(0, MSG_LEN - 1);
                bad_byte[k] = rand_bad();
            end
            win_key = $urandom_range(0, 6);
            run_and_check(BIG_MAX, 1'b0);
            repeat ($urandom_range(1, 4)) tick();
        end

        // finished already high when WAIT is entered: only a fresh rise starts the scan
        fake_en = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'h20;
        win_key = 0;
        @(posedge clk);
        #1 arc_finished = 1'b1;
        clear_log();
        pulse_start();
        repeat (25) tick();
        check("hi_no_scan", scan_lens.size(), 0);
        check("hi_a_own", 32'(a_own_s), 0);
        check("hi_busy", 32'(busy_s), 1);
        @(posedge clk);
        #1 arc_finished = 1'b0;
        repeat (2) @(posedge clk);
        #1 arc_finished = 1'b1;
        wait_done(80);
        check("hi_found", 32'(found_s), 1);
        check("hi_key", 32'(key_s), 0);
        check("hi_gap_count", entry_gaps.size(), 1);
        for (int i = 0; i < entry_gaps.size(); i++) check("hi_gap", entry_gaps[i], 1);
        disp_hold = 0;
        fake_en = 1'b1;
        repeat (3) tick();

        // Reset on the first WAIT cycle, while arc_start is high
        clear_log();
        pulse_start();
        tick();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_rst_outputs("rst_wait");
        repeat (2) tick();
        @(posedge clk);
        #1 reset = 1'b1;
        disp_hold = 0;
        repeat (15) tick();
        check("rst_wait_idle_busy", 32'(busy_s), 0);
        check("rst_wait_no_pulse", launches, 0);

        // Reset in the middle of a scan
        for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'h61;
        clear_log();
        pulse_start();
        wait_own(40);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_rst_outputs("rst_scan");
        repeat (2) tick();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (15) tick();
        check("rst_scan_launches", launches, 1);
        check("rst_scan_busy", 32'(busy_s), 0);

        // 4-key space, byte 0 always illegal: exhausts at key 3
        sel = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bad_pos[k]  = 0;
            bad_byte[k] = rand_bad();
        end
        win_key = 16;
        run_and_check(SMALL_MAX, 1'b0);
        repeat (3) tick();
        sel = 1'b0;

        check("arc_start_while_a_own", overlaps, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_search.md
# key_search

Brute-force key-search controller for the RC4 decryption circuit. Sits upstream of the arcfour core, which it drives with a candidate key and a one-cycle start pulse. Once arcfour finishes, the controller scans the decrypted message RAM for printable plaintext. It advances the key until the message checks clean or the 22-bit key space is exhausted, then reports the winning key.

## Interface
- MSG_LEN, 32: message length in bytes; bytes checked are A RAM addresses 0..MSG_LEN-1
- KEY_MAX, 22'h3FFFFF: last candidate tried; key[23:22] is always 0
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-low; all state and outputs clear immediately on assertion
- start_sig  in  1  single-cycle start pulse, already edge-trapped upstream
- arc_start  out  1  single-cycle start pulse to arcfour
- arc_finished  in  1  arcfour done level; internally rising-edge detected
- key  out  3x8  candidate key to arcfour, key[0] is LSB byte
- a_own  out  1  high while this block owns the A RAM port; top level muxes aAddr on it
- aAddr  out  8  A RAM read address
- aOut  in  8  A RAM read data, valid one cycle after address
- busy  out  1  search in progress
- found  out  1  valid key located; held until reset or next start_sig
- exhausted  out  1  KEY_MAX tried with no match; held like found

## Operation
- States: IDLE, LAUNCH, WAIT, SCAN, NEXT, DONE_OK, DONE_FAIL.
- Reset values: all outputs 0, key=0, state IDLE.
- IDLE: start_sig -> key=0, found=exhausted=0, busy=1, go to LAUNCH.
- LAUNCH: arc_start=1 for exactly one cycle -> WAIT.
- WAIT: stays until arc_finished rising edge -> SCAN with index=0, a_own=1. A level already high on entry does not count.
- SCAN: aAddr=index each cycle. The byte returned for index i is checked in the following cycle. A byte is legal if it is 8'h61..8'h7A ('a'..'z') or 8'h20.
  - First illegal byte -> abort the scan immediately -> NEXT.
  - All MSG_LEN bytes legal -> DONE_OK.
- NEXT: a_own=0.
  - If key[21:0]==KEY_MAX -> DONE_FAIL.
  - Otherwise key+1 -> LAUNCH.
  - Increment is 24-bit; key[23:22] never set.
- DONE_OK: found=1, busy=0, key frozen at the matching value -> IDLE.
- DONE_FAIL: exhausted=1, busy=0, key holds KEY_MAX -> IDLE.
- start_sig while busy: ignored.
- start_sig in IDLE with found/exhausted set: clears both flags and restarts from key 0.
- Reset mid-search: returns to IDLE, drops a_own and arc_start same cycle, no pulse emitted.

## Timing
- start_sig at cycle n -> arc_start at n+2 (IDLE at n+1 registers, LAUNCH drives).
- arc_finished rise at cycle m -> aAddr=0 at m+1.
- Full scan: MSG_LEN+1 cycles (pipelined issue/check). Abort on byte i: i+2 cycles after SCAN entry.
- NEXT -> LAUNCH: 1 cycle. arc_start never asserted while a_own=1.
- found/exhausted assert one cycle after the deciding check; busy falls the same cycle.

## Configuration
- KEY_SEARCH_PROGRESS_EN defined: key output tracks the live candidate at all times, for HEX display of progress.
- Not defined: key still feeds arcfour internally, but the externally visible copy (key_disp, same width) updates only in DONE_OK/DONE_FAIL. key_disp is present in both builds.

## Structure
- rc4_pkg: MSG_LEN default, KEY_W=24, KEY_MAX default, ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SP=8'h20, state enum ks_state_t.
- Sub-module msg_scanner: owns the index counter, 1-cycle read pipeline and legality check. Handshake is scan_go in -> scan_done/scan_ok out. The top FSM handles key stepping and arcfour handshake only.

## Test plan
- Reset held low mid-WAIT -> busy/found/exhausted/a_own/arc_start all 0 same cycle; IDLE after release.
- start_sig, fake arcfour returns finished after 10 cycles, RAM all 8'h61 -> found=1 with key=24'h000000, aAddr swept 0..31 once.
- RAM byte 3 = 8'h41 for keys 0..4, legal for key 5 -> arc_start pulses 6 times, each failing scan aborts after 5 SCAN cycles, found with key=24'h000005.
- KEY_MAX=22'h000003 override, RAM always illegal at byte 0 -> 4 launches, exhausted=1, key=24'h000003, found=0.
- start_sig pulsed during SCAN -> no effect; second start_sig after DONE_OK -> found clears, key restarts at 0.
- arc_finished already high on WAIT entry -> no scan until it falls and rises again.
